// File: rtl/mem_bus_arbiter.sv
// Shares one external memory bus between instruction fetch and load/store, one access at a time.
// Optional `MEM_BUS_ARB_ROUND_ROBIN_EN: alternate grants on contention instead of fixed mem priority.
module mem_bus_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_valid,
   input  logic [31:0] fetch_address,
   output logic [31:0] fetch_data,
   output logic        fetch_ready,
   input  logic        mem_load,
   input  logic        mem_store,
   input  logic [31:0] mem_address,
   input  logic [31:0] mem_store_data,
   input  logic [1:0]  mem_size,
   input  logic        mem_signed,
   output logic [31:0] mem_load_data,
   output logic        mem_ready,
   output logic        ext_valid,
   output logic        ext_instruction,
   input  logic        ext_ready,
   output logic [31:0] ext_address,
   output logic [31:0] ext_write_data,
   output logic [3:0]  ext_write_strobe,
   input  logic [31:0] ext_read_data
);

   typedef enum logic [2:0] {IDLE, FETCH, MEM, RESP_F, RESP_M} state_t;

   state_t      state_q, state_d;
   logic        ext_valid_q, ext_valid_d;
   logic        ext_instruction_q, ext_instruction_d;
   logic [31:0] ext_address_q, ext_address_d;
   logic [31:0] ext_write_data_q, ext_write_data_d;
   logic [3:0]  ext_write_strobe_q, ext_write_strobe_d;
   logic        fetch_ready_q, fetch_ready_d;
   logic        mem_ready_q, mem_ready_d;
   logic [31:0] fetch_data_q, fetch_data_d;
   logic [31:0] mem_load_data_q, mem_load_data_d;
   logic [1:0]  size_q, size_d;
   logic        sign_q, sign_d;
   logic [1:0]  off_q, off_d;
   logic        mem_req;
   logic        grant_mem;
   logic        unused_fetch_lsb;

   assign unused_fetch_lsb = ^fetch_address[1:0];

   function automatic logic [1:0] lane_offset(input logic [1:0] size, input logic [1:0] addr_lo);
      case (size)
         2'd0:    return addr_lo;
         2'd1:    return {addr_lo[1], 1'b0};
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic [3:0] byte_strobe(input logic [1:0] size, input logic [1:0] addr_lo);
      case (size)
         2'd0:    return 4'b0001 << addr_lo;
         2'd1:    return 4'b0011 << {addr_lo[1], 1'b0};
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] d);
      case (size)
         2'd0:    return {4{d[7:0]}};
         2'd1:    return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

   function automatic logic [31:0] extend_load(input logic [31:0] rd, input logic [1:0] size,
                                               input logic [1:0] off, input logic sgn);
      logic [31:0] sh;
      sh = rd >> {off, 3'b000};
      case (size)
         2'd0:    return sgn ? {{24{sh[7]}}, sh[7:0]} : {24'b0, sh[7:0]};
         2'd1:    return sgn ? {{16{sh[15]}}, sh[15:0]} : {16'b0, sh[15:0]};
         default: return sh;
      endcase
   endfunction

   assign mem_req = mem_load | mem_store;

`ifdef MEM_BUS_ARB_ROUND_ROBIN_EN
   // last_fetch_q = 1 means the previous grant went to fetch; resets that way so mem wins first.
   logic last_fetch_q, last_fetch_d;
   assign grant_mem = mem_req & (~fetch_valid | last_fetch_q);
`else
   assign grant_mem = mem_req;
`endif

   always_comb begin
      state_d            = state_q;
      ext_valid_d        = ext_valid_q;
      ext_instruction_d  = ext_instruction_q;
      ext_address_d      = ext_address_q;
      ext_write_data_d   = ext_write_data_q;
      ext_write_strobe_d = ext_write_strobe_q;
      fetch_ready_d      = 1'b0;
      mem_ready_d        = 1'b0;
      fetch_data_d       = fetch_data_q;
      mem_load_data_d    = mem_load_data_q;
      size_d             = size_q;
      sign_d             = sign_q;
      off_d              = off_q;
`ifdef MEM_BUS_ARB_ROUND_ROBIN_EN
      last_fetch_d       = last_fetch_q;
`endif
      case (state_q)
         IDLE: begin
            if (grant_mem) begin
               state_d            = MEM;
               ext_valid_d        = 1'b1;
               ext_instruction_d  = 1'b0;
               ext_address_d      = {mem_address[31:2], 2'b00};
               ext_write_data_d   = replicate(mem_size, mem_store_data);
               ext_write_strobe_d = mem_store ? byte_strobe(mem_size, mem_address[1:0]) : 4'b0000;
               size_d             = mem_size;
               sign_d             = mem_signed;
               off_d              = lane_offset(mem_size, mem_address[1:0]);
`ifdef MEM_BUS_ARB_ROUND_ROBIN_EN
               last_fetch_d       = 1'b0;
`endif
            end else if (fetch_valid) begin
               state_d            = FETCH;
               ext_valid_d        = 1'b1;
               ext_instruction_d  = 1'b1;
               ext_address_d      = {fetch_address[31:2], 2'b00};
               ext_write_data_d   = 32'h0;
               ext_write_strobe_d = 4'b0000;
`ifdef MEM_BUS_ARB_ROUND_ROBIN_EN
               last_fetch_d       = 1'b1;
`endif
            end
         end
         FETCH: begin
            if (ext_ready) begin
               state_d       = RESP_F;
               ext_valid_d   = 1'b0;
               fetch_data_d  = ext_read_data;
               fetch_ready_d = 1'b1;
            end
         end
         MEM: begin
            if (ext_ready) begin
               state_d         = RESP_M;
               ext_valid_d     = 1'b0;
               mem_load_data_d = extend_load(ext_read_data, size_q, off_q, sign_q);
               mem_ready_d     = 1'b1;
            end
         end
         // Response cycles always return to IDLE so a held request cannot be re-granted early.
         RESP_F, RESP_M: state_d = IDLE;
         default:        state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q            <= IDLE;
         ext_valid_q        <= 1'b0;
         ext_instruction_q  <= 1'b0;
         ext_address_q      <= 32'h0;
         ext_write_data_q   <= 32'h0;
         ext_write_strobe_q <= 4'b0000;
         fetch_ready_q      <= 1'b0;
         mem_ready_q        <= 1'b0;
         fetch_data_q       <= 32'h0;
         mem_load_data_q    <= 32'h0;
         size_q             <= 2'd0;
         sign_q             <= 1'b0;
         off_q              <= 2'd0;
`ifdef MEM_BUS_ARB_ROUND_ROBIN_EN
         last_fetch_q       <= 1'b1;
`endif
      end else begin
         state_q            <= state_d;
         ext_valid_q        <= ext_valid_d;
         ext_instruction_q  <= ext_instruction_d;
         ext_address_q      <= ext_address_d;
         ext_write_data_q   <= ext_write_data_d;
         ext_write_strobe_q <= ext_write_strobe_d;
         fetch_ready_q      <= fetch_ready_d;
         mem_ready_q        <= mem_ready_d;
         fetch_data_q       <= fetch_data_d;
         mem_load_data_q    <= mem_load_data_d;
         size_q             <= size_d;
         sign_q             <= sign_d;
         off_q              <= off_d;
`ifdef MEM_BUS_ARB_ROUND_ROBIN_EN
         last_fetch_q       <= last_fetch_d;
`endif
      end
   end

   assign ext_valid        = ext_valid_q;
   assign ext_instruction  = ext_instruction_q;
   assign ext_address      = ext_address_q;
   assign ext_write_data   = ext_write_data_q;
   assign ext_write_strobe = ext_write_strobe_q;
   assign fetch_ready      = fetch_ready_q;
   assign mem_ready        = mem_ready_q;
   assign fetch_data       = fetch_data_q;
   assign mem_load_data    = mem_load_data_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: transaction-level model checked every cycle plus directed literal checks.
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        fetch_valid = 1'b0;
   logic [31:0] fetch_address = 32'h0;
   logic [31:0] fetch_data;
   logic        fetch_ready;
   logic        mem_load = 1'b0;
   logic        mem_store = 1'b0;
   logic [31:0] mem_address = 32'h0;
   logic [31:0] mem_store_data = 32'h0;
   logic [1:0]  mem_size = 2'd0;
   logic        mem_signed = 1'b0;
   logic [31:0] mem_load_data;
   logic        mem_ready;
   logic        ext_valid;
   logic        ext_instruction;
   logic        ext_ready = 1'b0;
   logic [31:0] ext_address;
   logic [31:0] ext_write_data;
   logic [3:0]  ext_write_strobe;
   logic [31:0] ext_read_data = 32'h0;

   int n_vec = 0;
   int n_bad = 0;

   mem_bus_arbiter dut (
      .clk(clk), .reset(reset),
      .fetch_valid(fetch_valid), .fetch_address(fetch_address),
      .fetch_data(fetch_data), .fetch_ready(fetch_ready),
      .mem_load(mem_load), .mem_store(mem_store), .mem_address(mem_address),
      .mem_store_data(mem_store_data), .mem_size(mem_size), .mem_signed(mem_signed),
      .mem_load_data(mem_load_data), .mem_ready(mem_ready),
      .ext_valid(ext_valid), .ext_instruction(ext_instruction), .ext_ready(ext_ready),
      .ext_address(ext_address), .ext_write_data(ext_write_data),
      .ext_write_strobe(ext_write_strobe), .ext_read_data(ext_read_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Byte-lane arithmetic for the model: how many bytes, which lane the access starts on.
   function automatic int f_bytes(input logic [1:0] size);
      return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
   endfunction

   function automatic int f_off(input logic [1:0] size, input logic [31:0] addr);
      int o;
      o = int'(addr % 4);
      if (size == 2'd1) o = o - (o % 2);
      if (size >= 2'd2) o = 0;
      return o;
   endfunction

   function automatic logic [3:0] f_strobe(input logic [1:0] size, input logic [31:0] addr);
      logic [3:0] s;
      int off, nb;
      s = 4'b0000;
      off = f_off(size, addr);
      nb = f_bytes(size);
      for (int i = 0; i < 4; i++) if (i >= off && i < off + nb) s[i] = 1'b1;
      return s;
   endfunction

   function automatic logic [31:0] f_wdata(input logic [1:0] size, input logic [31:0] d);
      logic [31:0] w;
      int nb;
      nb = f_bytes(size);
      w = 32'h0;
      for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % nb) +: 8];
      return w;
   endfunction

   function automatic logic [31:0] f_load(input logic [31:0] rd, input logic [1:0] size,
                                          input logic [31:0] addr, input logic sgn);
      logic [31:0] v;
      int off, nb;
      off = f_off(size, addr);
      nb = f_bytes(size);
      v = 32'h0;
      for (int k = 0; k < nb; k++) v[8*k +: 8] = rd[8*(off + k) +: 8];
      if (sgn && nb < 4 && v[8*nb - 1])
         for (int k = nb; k < 4; k++) v[8*k +: 8] = 8'hFF;
      return v;
   endfunction

   // Transaction model: phase 0 waiting for a request, 1 on the bus, 2 reporting completion.
   int          m_phase = 0;
   bit          m_is_fetch = 1'b0;
   bit          m_is_store = 1'b0;
   bit          m_sign = 1'b0;
   bit          m_last_fetch = 1'b1;
   bit          m_pick_mem;
   logic [1:0]  m_size = 2'd0;
   logic [31:0] m_addr = 32'h0;
   logic [31:0] m_data = 32'h0;
   logic [31:0] m_rd = 32'h0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_phase = 0;
         m_last_fetch = 1'b1;
      end else begin
         if (m_phase == 0) begin
`ifdef MEM_BUS_ARB_ROUND_ROBIN_EN
            m_pick_mem = (mem_load || mem_store) && (!fetch_valid || m_last_fetch);
`else
            m_pick_mem = mem_load || mem_store;
`endif
            if (m_pick_mem) begin
               m_phase = 1; m_is_fetch = 1'b0; m_is_store = mem_store;
               m_addr = mem_address; m_data = mem_store_data;
               m_size = mem_size; m_sign = mem_signed; m_last_fetch = 1'b0;
            end else if (fetch_valid) begin
               m_phase = 1; m_is_fetch = 1'b1; m_is_store = 1'b0;
               m_addr = fetch_address; m_last_fetch = 1'b1;
            end
         end else if (m_phase == 1) begin
            if (ext_ready) begin
               m_rd = ext_read_data;
               m_phase = 2;
            end
         end else begin
            m_phase = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         check("rst ext_valid", {31'b0, ext_valid}, 32'h0);
         check("rst ext_instruction", {31'b0, ext_instruction}, 32'h0);
         check("rst ext_address", ext_address, 32'h0);
         check("rst ext_write_data", ext_write_data, 32'h0);
         check("rst ext_write_strobe", {28'b0, ext_write_strobe}, 32'h0);
         check("rst fetch_ready", {31'b0, fetch_ready}, 32'h0);
         check("rst mem_ready", {31'b0, mem_ready}, 32'h0);
         check("rst fetch_data", fetch_data, 32'h0);
         check("rst mem_load_data", mem_load_data, 32'h0);
      end else begin
         check("ext_valid", {31'b0, ext_valid}, {31'b0, m_phase == 1});
         if (m_phase == 1) begin
            check("ext_instruction", {31'b0, ext_instruction}, {31'b0, m_is_fetch});
            check("ext_address", ext_address, m_addr & ~32'h3);
            check("ext_write_strobe", {28'b0, ext_write_strobe},
                  {28'b0, m_is_store ? f_strobe(m_size, m_addr) : 4'b0000});
            if (m_is_store) check("ext_write_data", ext_write_data, f_wdata(m_size, m_data));
         end
         check("fetch_ready", {31'b0, fetch_ready}, {31'b0, m_phase == 2 && m_is_fetch});
         check("mem_ready", {31'b0, mem_ready}, {31'b0, m_phase == 2 && !m_is_fetch});
         if (m_phase == 2 && m_is_fetch) check("fetch_data", fetch_data, m_rd);
         if (m_phase == 2 && !m_is_fetch && !m_is_store)
            check("mem_load_data", mem_load_data, f_load(m_rd, m_size, m_addr, m_sign));
      end
   end

   task automatic wait_grant();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (ext_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("grant timeout ext_valid", {31'b0, ext_valid}, 32'h1);
   endtask

   // Holds the bus busy for 'waits' cycles, then completes it; returns in the ready cycle.
   task automatic complete(input int waits, input logic [31:0] rd);
      repeat (waits) begin
         @(posedge clk); #1;
      end
      ext_ready = 1'b1;
      ext_read_data = rd;
      @(posedge clk); #1;
      ext_ready = 1'b0;
      ext_read_data = 32'hDEADBEEF;
   endtask

   task automatic mem_req(input bit ld, input bit st, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] sz, input bit sg);
      mem_load = ld; mem_store = st; mem_address = a;
      mem_store_data = d; mem_size = sz; mem_signed = sg;
   endtask

   logic grants [4];
   logic exp_grants [4];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;

      // Single fetch, minimum latency
      fetch_address = 32'h0000_1004; fetch_valid = 1'b1;
      wait_grant();
      check("fetch ext_instruction", {31'b0, ext_instruction}, 32'h1);
      check("fetch ext_address", ext_address, 32'h0000_1004);
      check("fetch strobe", {28'b0, ext_write_strobe}, 32'h0);
      complete(0, 32'h00A0_0093);
      check("fetch_ready pulse", {31'b0, fetch_ready}, 32'h1);
      check("fetch_data", fetch_data, 32'h00A0_0093);
      fetch_valid = 1'b0;
      @(posedge clk); #1;
      check("fetch_ready one cycle", {31'b0, fetch_ready}, 32'h0);

      // Signed and unsigned byte loads from lane 3
      mem_req(1, 0, 32'h0000_2003, 32'h0, 2'd0, 1);
      wait_grant();
      complete(1, 32'h80FF_7F01);
      check("lb signed", mem_load_data, 32'hFFFF_FF80);
      mem_load = 1'b0;
      @(posedge clk); #1;
      mem_req(1, 0, 32'h0000_2003, 32'h0, 2'd0, 0);
      wait_grant();
      complete(0, 32'h80FF_7F01);
      check("lbu", mem_load_data, 32'h0000_0080);
      mem_load = 1'b0;

      // Half store on upper lanes
      mem_req(0, 1, 32'h0000_2002, 32'h1234_ABCD, 2'd1, 0);
      wait_grant();
      check("sh strobe", {28'b0, ext_write_strobe}, 32'hC);
      check("sh wdata", ext_write_data, 32'hABCD_ABCD);
      check("sh address", ext_address, 32'h0000_2000);
      complete(2, 32'h0);
      check("sh mem_ready", {31'b0, mem_ready}, 32'h1);
      mem_store = 1'b0;

      // Signed half load, word load with misaligned address, byte store, load+store together
      mem_req(1, 0, 32'h0000_2002, 32'h0, 2'd1, 1);
      wait_grant();
      complete(0, 32'h8001_7F00);
      check("lh signed", mem_load_data, 32'hFFFF_8001);
      mem_load = 1'b0;
      mem_req(1, 0, 32'h0000_2005, 32'h0, 2'd2, 1);
      wait_grant();
      check("lw address", ext_address, 32'h0000_2004);
      complete(1, 32'h8765_4321);
      check("lw data", mem_load_data, 32'h8765_4321);
      mem_load = 1'b0;
      mem_req(0, 1, 32'h0000_2001, 32'h0000_0055, 2'd0, 0);
      wait_grant();
      check("sb strobe", {28'b0, ext_write_strobe}, 32'h2);
      check("sb wdata", ext_write_data, 32'h5555_5555);
      complete(0, 32'h0);
      mem_store = 1'b0;
      mem_req(1, 1, 32'h0000_2008, 32'hCAFE_F00D, 2'd3, 0);
      wait_grant();
      check("ld+st as store strobe", {28'b0, ext_write_strobe}, 32'hF);
      complete(0, 32'h0);
      mem_load = 1'b0; mem_store = 1'b0;

      // Fetch withdrawn after grant still completes
      fetch_address = 32'h0000_4000; fetch_valid = 1'b1;
      wait_grant();
      fetch_valid = 1'b0;
      complete(2, 32'h0000_0013);
      check("withdrawn fetch_ready", {31'b0, fetch_ready}, 32'h1);
      check("withdrawn fetch_data", fetch_data, 32'h0000_0013);
      @(posedge clk); #1;

      // Contention with both requests held
      fetch_address = 32'h0000_1000; fetch_valid = 1'b1;
      mem_req(1, 0, 32'h0000_3004, 32'h0, 2'd2, 0);
      for (int g = 0; g < 4; g++) begin
         wait_grant();
         grants[g] = ext_instruction;
         complete(3, 32'h1111_0000 + 32'(g));
      end
      fetch_valid = 1'b0; mem_load = 1'b0;
`ifdef MEM_BUS_ARB_ROUND_ROBIN_EN
      exp_grants = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
      exp_grants = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
      for (int g = 0; g < 4; g++) check("grant order", {31'b0, grants[g]}, {31'b0, exp_grants[g]});
      repeat (2) @(posedge clk);
      #1;

      // Reset during a mem access abandons it
      mem_req(1, 0, 32'h0000_5000, 32'h0, 2'd2, 0);
      wait_grant();
      @(posedge clk); #1;
      #2 reset = 1'b0;
      #1;
      check("async reset ext_valid", {31'b0, ext_valid}, 32'h0);
      check("async reset mem_ready", {31'b0, mem_ready}, 32'h0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      check("regrant after reset", {31'b0, ext_valid}, 32'h1);
      check("regrant address", ext_address, 32'h0000_5000);
      complete(0, 32'h0000_0077);
      check("regrant mem_ready", {31'b0, mem_ready}, 32'h1);
      check("regrant data", mem_load_data, 32'h0000_0077);
      mem_load = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Sequential arbiter and access sequencer that shares the core's single external memory bus between the instruction-fetch port and the load/store port of the pipeline. It sits between `pipeline` and the `ext_*` pins of `core`, in place of a purely combinational bus adapter. It grants one requester at a time and holds a registered request on the bus until `ext_ready`. It then returns a one-cycle ready pulse with aligned, sign/zero-extended load data or fetched instruction word.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low (0 = reset)
- `fetch_valid`  in  1  fetch request; held with stable `fetch_address` until `fetch_ready`
- `fetch_address`  in  32  instruction address (word-aligned; bits [1:0] ignored)
- `fetch_data`  out  32  fetched word, valid while `fetch_ready`=1
- `fetch_ready`  out  1  one-cycle completion pulse for fetch
- `mem_load`, `mem_store`  in  1 each  data request; held with stable address/data/size/signed until `mem_ready`
- `mem_address`  in  32  byte address
- `mem_store_data`  in  32  store data, right-aligned
- `mem_size`  in  2  0 byte, 1 half, 2/3 word
- `mem_signed`  in  1  sign-extend loads
- `mem_load_data`  out  32  extended load result, valid while `mem_ready`=1
- `mem_ready`  out  1  one-cycle completion pulse for load/store
- `ext_valid`  out  1  bus request
- `ext_instruction`  out  1  1 = current bus access is a fetch
- `ext_ready`  in  1  bus completion, sampled on `clk`
- `ext_address`  out  32  word address `{addr[31:2],2'b00}`
- `ext_write_data`  out  32  replicated store data
- `ext_write_strobe`  out  4  byte enables; 0 for reads
- `ext_read_data`  in  32  read word, valid when `ext_ready`=1

## Operation
- FSM states: IDLE, FETCH, MEM, RESP_F, RESP_M.
- IDLE: sample requests.
  - Winner's address, data, strobe and kind are registered into `ext_*`. Next state is FETCH or MEM with `ext_valid`=1.
  - No request: stay in IDLE.
- FETCH/MEM: `ext_*` outputs held constant.
  - `ext_ready`=1 at an edge captures `ext_read_data` and moves to RESP_F or RESP_M.
  - Otherwise wait indefinitely. No timeout.
- RESP_F/RESP_M:
  - The matching ready output is 1 for exactly this cycle, with the captured data.
  - `ext_valid`=0.
  - Next state is always IDLE, so a requester's still-asserted request is never re-granted during its own ready cycle.
- Arbitration: when both requests are set in IDLE, mem wins (fixed priority).
- `mem_load` and `mem_store` both set: treated as a store.
- Strobe:
  - byte: `4'b0001 << addr[1:0]`
  - half: `4'b0011 << {addr[1],1'b0}`, `addr[0]` ignored
  - word: `4'b1111`, `addr[1:0]` ignored
- Write data:
  - byte: `{4{d[7:0]}}`
  - half: `{2{d[15:0]}}`
  - word: `d`
- Load data: read word shifted right by 8·offset, where offset uses the same alignment rule as the strobe. Then zero- or sign-extend from bit 7, 15 or 31 per `mem_size`/`mem_signed`.
- `fetch_data` = raw read word.

## Timing
- Reset values:
  - state IDLE
  - `ext_valid`=0, `ext_instruction`=0, `ext_address`=0, `ext_write_data`=0, `ext_write_strobe`=0
  - `fetch_ready`=0, `mem_ready`=0, `fetch_data`=0, `mem_load_data`=0
- Minimum latency:
  - request sampled at edge 0
  - `ext_valid` high cycle 1
  - `ext_ready`=1 at edge 1
  - ready pulse cycle 2
  - IDLE cycle 3
  - next grant `ext_valid` cycle 4
- Throughput is one access per 3 cycles at best.
- All outputs are registered; no combinational path from `ext_ready` or requests to any output.
- Reset asserted mid-access: asynchronously forces IDLE, drops `ext_valid`, and abandons the access with no ready pulse. Requester must reissue.
- Request withdrawn while granted: ignored. The access completes and the ready pulse is still issued.

## Configuration
- `MEM_BUS_ARB_ROUND_ROBIN_EN`
  - Defined: a 1-bit last-grant register (reset value = fetch) is added, and on contention the requester not granted last wins. Mem therefore wins the first contention, then the two alternate.
  - Undefined: fixed mem priority as above.
- Single requester: behaviour is identical either way.

## Test plan
- Fetch only, `fetch_address`=0x1004, `ext_ready` high cycle 1, `ext_read_data`=0x00A00093:
  - `ext_valid`=1, `ext_instruction`=1, `ext_address`=0x1004, strobe 0 in cycle 1
  - `fetch_ready`=1, `fetch_data`=0x00A00093 in cycle 2 only
- Signed byte load at 0x2003, read word 0x80FF7F01: `mem_load_data`=0xFFFFFF80. Same with `mem_signed`=0: 0x00000080.
- Half store at 0x2002, data 0x1234ABCD: `ext_write_strobe`=0xC, `ext_write_data`=0xABCDABCD, `ext_address`=0x2000, `mem_ready` pulse after `ext_ready`.
- Fetch and load both held continuously, `ext_ready` after 3 wait cycles each:
  - fixed priority: grants MEM, MEM, …
  - with macro: grants MEM, FETCH, MEM, FETCH
  - `ext_valid` and `ext_address` are stable throughout the wait cycles.
- `reset`=0 pulsed during a MEM access with `ext_ready`=0: `ext_valid` falls immediately, no `mem_ready`. After release, the still-held request is granted again in 1 cycle.
